// File: rtl/ram_if_pkg.sv
// Shared definitions for the MIG app-interface line reader/writer pair.
package ram_if_pkg;

    localparam logic [2:0] MIG_CMD_WRITE  = 3'b000;
    localparam logic [2:0] MIG_CMD_READ   = 3'b001;
    localparam int         WORDS_PER_LINE = 8;
    localparam int         WORD_W         = 16;

    typedef enum logic [1:0] {
        WR_COLLECT,
        WR_DATA0,
        WR_DATA1,
        WR_CMD
    } writer_state_e;

    typedef struct packed {
        logic [2:0]        offset;
        logic [WORD_W-1:0] data;
    } line_word_t;

endpackage

// File: rtl/ram_line_buffer.sv
// One 8-word burst line: word storage, per-word valid bits, line tag and
// app-beat data/mask generation.
module ram_line_buffer
    import ram_if_pkg::*;
#(
    parameter int TAG_WIDTH      = 24,
    parameter int APP_DATA_WIDTH = 64,
    parameter int APP_MASK_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      store,
    input  line_word_t                word,
    input  logic [TAG_WIDTH-1:0]      store_tag,
    input  logic                      clear,
    input  logic                      beat_sel,
    output logic                      empty,
    output logic                      full_next,
    output logic [TAG_WIDTH-1:0]      tag,
    output logic [APP_DATA_WIDTH-1:0] beat_data,
    output logic [APP_MASK_WIDTH-1:0] beat_mask
);

    logic [WORDS_PER_LINE-1:0][WORD_W-1:0] words, words_nxt;
    logic [WORDS_PER_LINE-1:0]             valid, valid_nxt;
    logic [3:0]                            beat_valid;

    always_comb begin
        words_nxt = words;
        valid_nxt = valid;
        if (clear) begin
            valid_nxt = '0;
        end else if (store) begin
            words_nxt[word.offset] = word.data;
            valid_nxt[word.offset] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words <= '0;
            valid <= '0;
            tag   <= '0;
        end else begin
            words <= words_nxt;
            valid <= valid_nxt;
            if (store) tag <= store_tag;
        end
    end

    assign empty     = ~|valid;
    assign full_next = &valid_nxt;

    // Beats are built from the post-update contents so the word accepted on
    // the auto-flush cycle lands in the registered beat outputs.
    assign beat_data  = beat_sel ? words_nxt[7:4] : words_nxt[3:0];
    assign beat_valid = beat_sel ? valid_nxt[7:4] : valid_nxt[3:0];

    always_comb begin
        beat_mask = '1;
        for (int j = 0; j < 4; j++) beat_mask[2*j +: 2] = {2{~beat_valid[j]}};
    end

endmodule

// File: rtl/ram_writer.sv
// Coalesces 16-bit word writes into 8-word lines and drains each line to the
// MIG app interface as two write-data beats followed by one write command.
module ram_writer
    import ram_if_pkg::*;
#(
    parameter int ADDR_WIDTH     = 27,
    parameter int APP_DATA_WIDTH = 64,
    parameter int APP_MASK_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     write_address,
    input  logic [WORD_W-1:0]         write_data,
    input  logic                      write_valid,
    output logic                      write_ready,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      busy,
    output logic [ADDR_WIDTH-1:0]     ram_address,
    output logic [2:0]                ram_cmd,
    output logic                      ram_en,
    input  logic                      ram_rdy,
    output logic [APP_DATA_WIDTH-1:0] ram_wdf_data,
    output logic                      ram_wdf_wren,
    output logic                      ram_wdf_end,
    output logic [APP_MASK_WIDTH-1:0] ram_wdf_mask,
    input  logic                      ram_wdf_rdy
);

    localparam int TAG_WIDTH = ADDR_WIDTH - 3;

    writer_state_e               state, state_nxt;
    logic                        flush_pending, set_pending;
    logic                        empty, full_next, tag_hit, accept, drain_done;
    logic                        empty_flush, wren_nxt;
    logic [TAG_WIDTH-1:0]        tag;
    logic [APP_DATA_WIDTH-1:0]   beat_data;
    logic [APP_MASK_WIDTH-1:0]   beat_mask;

    assign tag_hit     = write_address[ADDR_WIDTH-1:3] == tag;
    assign write_ready = (state == WR_COLLECT) && !flush && (empty || tag_hit);
    assign accept      = write_valid && write_ready;
    assign drain_done  = (state == WR_CMD) && ram_rdy;
    // Gate on flush_done so a level flush still high after its pulse does not retrigger.
    assign empty_flush = (state == WR_COLLECT) && flush && empty && !flush_done;
    assign wren_nxt    = (state_nxt == WR_DATA0) || (state_nxt == WR_DATA1);
    assign ram_cmd     = MIG_CMD_WRITE;

    ram_line_buffer #(
        .TAG_WIDTH      (TAG_WIDTH),
        .APP_DATA_WIDTH (APP_DATA_WIDTH),
        .APP_MASK_WIDTH (APP_MASK_WIDTH)
    ) u_line (
        .clk       (clk),
        .reset     (reset),
        .store     (accept),
        .word      ('{offset: write_address[2:0], data: write_data}),
        .store_tag (write_address[ADDR_WIDTH-1:3]),
        .clear     (drain_done),
        .beat_sel  (state_nxt == WR_DATA1),
        .empty     (empty),
        .full_next (full_next),
        .tag       (tag),
        .beat_data (beat_data),
        .beat_mask (beat_mask)
    );

    always_comb begin
        state_nxt   = state;
        set_pending = 1'b0;
        case (state)
            WR_COLLECT: begin
                if (flush) begin
                    if (!empty) begin
                        state_nxt   = WR_DATA0;
                        set_pending = 1'b1;
                    end
                end else if (full_next || (write_valid && !write_ready)) begin
                    // Full line, or a write to another line that must wait for this one.
                    state_nxt = WR_DATA0;
                end
            end
            WR_DATA0: if (ram_wdf_rdy) state_nxt = WR_DATA1;
            WR_DATA1: if (ram_wdf_rdy) state_nxt = WR_CMD;
            WR_CMD:   if (ram_rdy)     state_nxt = WR_COLLECT;
            default:                   state_nxt = WR_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= WR_COLLECT;
            flush_pending <= 1'b0;
            flush_done    <= 1'b0;
            busy          <= 1'b0;
            ram_en        <= 1'b0;
            ram_address   <= '0;
            ram_wdf_wren  <= 1'b0;
            ram_wdf_end   <= 1'b0;
            ram_wdf_data  <= '0;
            ram_wdf_mask  <= '1;
        end else begin
            state         <= state_nxt;
            if (set_pending)     flush_pending <= 1'b1;
            else if (drain_done) flush_pending <= 1'b0;
            flush_done    <= (drain_done && flush_pending) || empty_flush;
            busy          <= state_nxt != WR_COLLECT;
            ram_en        <= state_nxt == WR_CMD;
            ram_address   <= (state_nxt == WR_CMD) ? {tag, 3'b000} : '0;
            ram_wdf_wren  <= wren_nxt;
            ram_wdf_end   <= state_nxt == WR_DATA1;
            ram_wdf_data  <= wren_nxt ? beat_data : '0;
            ram_wdf_mask  <= wren_nxt ? beat_mask : '1;
        end
    end

endmodule

// File: tb/tb_ram_writer.sv
// Randomized scoreboard bench for ram_writer: a line-level model predicts each
// burst and an app-bus monitor checks beats, commands, holds and flush pulses.
module tb_ram_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [26:0] write_address = '0;
    logic [15:0] write_data = '0;
    logic        write_valid = 1'b0;
    logic        write_ready;
    logic        flush = 1'b0;
    logic        flush_done, busy;
    logic [26:0] ram_address;
    logic [2:0]  ram_cmd;
    logic        ram_en;
    logic        ram_rdy = 1'b0;
    logic [63:0] ram_wdf_data;
    logic        ram_wdf_wren, ram_wdf_end;
    logic [7:0]  ram_wdf_mask;
    logic        ram_wdf_rdy = 1'b0;

    ram_writer dut (
        .clk(clk), .reset(reset),
        .write_address(write_address), .write_data(write_data),
        .write_valid(write_valid), .write_ready(write_ready),
        .flush(flush), .flush_done(flush_done), .busy(busy),
        .ram_address(ram_address), .ram_cmd(ram_cmd), .ram_en(ram_en), .ram_rdy(ram_rdy),
        .ram_wdf_data(ram_wdf_data), .ram_wdf_wren(ram_wdf_wren), .ram_wdf_end(ram_wdf_end),
        .ram_wdf_mask(ram_wdf_mask), .ram_wdf_rdy(ram_wdf_rdy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [26:0]      addr;
        logic [1:0][63:0] data;
        logic [1:0][7:0]  mask;
        logic             fd;
    } burst_t;

    burst_t      q[$];
    int          checks = 0, errors = 0;
    logic [15:0] mw[8];
    logic [7:0]  mv = '0;
    logic [23:0] mtag = '0;
    bit          draining = 0;
    int          exp_fd_total = 0, fd_count = 0, whs_count = 0, chs_count = 0;
    bit          rand_rdy = 0;
    logic        wdf_rdy_val = 1'b1, rdy_val = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", nm, $time);
    endtask

    function automatic logic [63:0] keep_bits(input logic [7:0] m);
        logic [63:0] k = '0;
        for (int i = 0; i < 8; i++) k[8*i +: 8] = m[i] ? 8'h00 : 8'hFF;
        return k;
    endfunction

    // Snapshot the model line as the burst the DUT must emit.
    task automatic commit(input bit fd_flag);
        burst_t b;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            if (mv[k]) b.data[k/4] = b.data[k/4] | (64'(mw[k]) << (16*(k%4)));
            else       b.mask[k/4] = b.mask[k/4] | (8'h3 << (2*(k%4)));
        end
        b.addr = {mtag, 3'b000};
        b.fd   = fd_flag;
        q.push_back(b);
        mv       = '0;
        draining = 1;
    endtask

    task automatic do_write(input logic [26:0] a, input logic [15:0] d);
        bit er;
        @(negedge clk);
        write_valid = 1'b1; write_address = a; write_data = d; flush = 1'b0;
        for (int n = 0; n < 400; n++) begin
            #1;
            er = !draining && (mv == 0 || a[26:3] == mtag);
            chk("write_ready", write_ready, er);
            if (write_ready) begin
                if (mv == 0) mtag = a[26:3];
                mw[a[2:0]] = d;
                mv[a[2:0]] = 1'b1;
                if (mv == 8'hFF) commit(0);
                return;
            end
            if (!draining && mv != 0 && a[26:3] != mtag) commit(0);
            @(negedge clk);
        end
        timeout("write_accept");
    endtask

    task automatic wait_drain();
        @(negedge clk);
        write_valid = 1'b0;
        #1;
        for (int n = 0; n < 400 && draining; n++) begin
            @(negedge clk);
            #1;
        end
        if (draining) timeout("drain");
    endtask

    task automatic do_flush(input bit with_write);
        logic [2:0] off;
        wait_drain();
        off = 3'($urandom_range(0, 7));
        flush = 1'b1;
        write_valid = with_write;
        write_address = {mtag, off};
        #1;
        chk("flush_blocks_write", write_ready, 0);
        exp_fd_total++;
        if (mv == 0) begin
            @(negedge clk);
            #1;
            chk("empty_flush_done", flush_done, 1);
        end else begin
            commit(1);
            for (int n = 0; n < 400 && draining; n++) begin
                @(negedge clk);
                #1;
            end
            if (draining) timeout("flush_drain");
        end
        flush = 1'b0;
        write_valid = 1'b0;
    endtask

    // App-bus monitor: handshakes recorded at one falling edge took effect at
    // the following rising edge and are scored at the next falling edge.
    int          beat_idx = 0;
    bit          p_ok = 0;
    logic        p_wren, p_wrdy, p_end, p_en, p_rdy;
    logic [63:0] p_data;
    logic [7:0]  p_mask;
    logic [26:0] p_addr;

    always @(negedge clk) begin
        if (reset) begin
            beat_idx = 0;
        end else begin
            if (p_ok && p_wren && p_wrdy) begin
                whs_count++;
                if (q.size() == 0 || beat_idx > 1) begin
                    timeout("unexpected_beat");
                end else begin
                    chk("beat_data", p_data & keep_bits(q[0].mask[beat_idx]),
                        q[0].data[beat_idx] & keep_bits(q[0].mask[beat_idx]));
                    chk("beat_mask", p_mask, q[0].mask[beat_idx]);
                    chk("beat_end", p_end, beat_idx == 1);
                    beat_idx++;
                end
            end
            if (p_ok && p_en && p_rdy) begin
                chs_count++;
                if (q.size() == 0) begin
                    timeout("unexpected_cmd");
                end else begin
                    chk("beats_before_cmd", beat_idx, 2);
                    chk("cmd_address", p_addr, q[0].addr);
                    chk("cmd_code", ram_cmd, 3'b000);
                    chk("flush_done_at_cmd", flush_done, q[0].fd);
                    void'(q.pop_front());
                end
                beat_idx = 0;
                draining = 0;
            end
            if (p_ok && p_wren && !p_wrdy) begin
                chk("wdf_hold_data", ram_wdf_data, p_data);
                chk("wdf_hold_ctl", {ram_wdf_wren, ram_wdf_end, ram_wdf_mask}, {1'b1, p_end, p_mask});
            end
            if (p_ok && p_en && !p_rdy) chk("cmd_hold", {ram_en, ram_address}, {1'b1, p_addr});
            if (q.size() == 0) chk("idle_bus", {ram_wdf_wren, ram_en}, 2'b00);
            chk("busy", busy, draining);
            if (flush_done) fd_count++;
        end
        if (rand_rdy) begin
            ram_wdf_rdy = $urandom_range(0, 3) != 0;
            ram_rdy     = $urandom_range(0, 3) != 0;
        end else begin
            ram_wdf_rdy = wdf_rdy_val;
            ram_rdy     = rdy_val;
        end
        p_ok   = !reset;
        p_wren = ram_wdf_wren; p_wrdy = ram_wdf_rdy; p_end = ram_wdf_end;
        p_data = ram_wdf_data; p_mask = ram_wdf_mask;
        p_en   = ram_en; p_rdy = ram_rdy; p_addr = ram_address;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, c0, f0;
        for (int i = 0; i < 8; i++) mw[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outputs", {ram_en, ram_wdf_wren, ram_wdf_end, flush_done, busy}, 5'b0);
        chk("rst_address", ram_address, 0);
        chk("rst_data", ram_wdf_data, 0);
        chk("rst_mask", ram_wdf_mask, 8'hFF);
        chk("rst_write_ready", write_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // line fill
        for (int i = 0; i < 8; i++) do_write(27'h100 + 27'(i), 16'h1000 + 16'(i));
        wait_drain();
        // partial flush
        do_write(27'h202, 16'hBEEF);
        do_flush(0);
        // tag miss, then flush with a competing write
        do_write(27'h010, 16'hAAAA);
        do_write(27'h018, 16'h5555);
        do_flush(1);

        // backpressure
        wdf_rdy_val = 1'b0; rdy_val = 1'b0;
        w0 = whs_count; c0 = chs_count;
        for (int i = 0; i < 8; i++) do_write(27'h400 + 27'(i), 16'(i * 16'h0101));
        repeat (5) @(negedge clk);
        #1 wdf_rdy_val = 1'b1;
        for (int n = 0; n < 50 && !ram_en; n++) begin
            @(negedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        #1 rdy_val = 1'b1;
        wait_drain();
        chk("bp_wren_handshakes", whs_count - w0, 2);
        chk("bp_en_handshakes", chs_count - c0, 1);

        // empty flush and overwrite
        w0 = whs_count; c0 = chs_count; f0 = fd_count;
        do_flush(0);
        repeat (2) @(negedge clk);
        chk("empty_flush_no_bus", {32'(whs_count - w0), 32'(chs_count - c0)}, 0);
        chk("empty_flush_one_pulse", fd_count - f0, 1);
        do_write(27'h300, 16'h1111);
        do_write(27'h300, 16'h2222);
        do_flush(0);

        // reset while beat 1 is stalled
        do_write(27'h5A3, 16'h7777);
        wdf_rdy_val = 1'b0; rdy_val = 1'b0;
        @(negedge clk);
        write_valid = 1'b0; flush = 1'b1;
        #1 commit(1);
        @(negedge clk);
        #1 wdf_rdy_val = 1'b1;
        @(negedge clk);
        #1 wdf_rdy_val = 1'b0;
        @(negedge clk);
        #1 chk("in_data1", {ram_wdf_wren, ram_wdf_end}, 2'b11);
        reset = 1'b1; flush = 1'b0;
        #1;
        chk("rst_async_wren_busy", {ram_wdf_wren, busy, ram_en, ram_wdf_end}, 4'b0);
        q.delete();
        draining = 0; mv = '0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        wdf_rdy_val = 1'b1; rdy_val = 1'b1;
        write_address = 27'h5A3;
        #1 chk("post_rst_ready", write_ready, 1);
        w0 = whs_count; c0 = chs_count;
        repeat (10) @(negedge clk);
        chk("post_rst_no_stale", {32'(whs_count - w0), 32'(chs_count - c0)}, 0);

        // randomized traffic
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 11) == 0) do_flush($urandom_range(0, 1) == 1);
            else do_write(27'h1000 + 27'($urandom_range(0, 31)), 16'($urandom));
        end
        do_flush(0);
        wait_drain();
        repeat (5) @(negedge clk);
        chk("flush_done_total", fd_count, exp_fd_total);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
